spi_multiword_master: RTL and testbench



---
 rtl/spi_multiword_master.sv | 137 +++++++++++++
 tb/tb_spi_multiword_master.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_multiword_master.sv
// rtl/spi_multiword_master.sv - SPI master that shifts a burst of NUM_WORDS words per start.
// SCK polarity/phase and slave-select policy are latched per burst.
module spi_multiword_master #(
  parameter int DATA_BITS = 8,
  parameter int NUM_WORDS = 4,
  parameter int CLK_DIV   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [1:0]                     mode,
  input  logic                           tied_SS,
  input  logic [NUM_WORDS*DATA_BITS-1:0] tx_words,
  output logic [NUM_WORDS*DATA_BITS-1:0] rx_words,
  output logic                           busy,
  output logic                           done,
  output logic                           SCK,
  output logic                           SS,
  output logic                           MOSI,
  input  logic                           MISO
);
  localparam int WW = $clog2(NUM_WORDS + 1);
  localparam int DW = $clog2(CLK_DIV);
  localparam int TW = $clog2(2 * DATA_BITS);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP, DONE} state_t;
  state_t state, state_nx;

  logic [DW-1:0]                  div_cnt;
  logic [TW-1:0]                  tog_cnt;
  logic [WW-1:0]                  word_idx;
  logic [WW-1:0]                  load_idx;
  logic                           cpha, tied;
  logic [NUM_WORDS*DATA_BITS-1:0] tx_lat;
  logic [DATA_BITS-1:0]           tx_sh, rx_sh, load_word, rx_fin;
  logic                           div_end, last_tog, last_word, leading;

  assign div_end   = (div_cnt == DW'(CLK_DIV - 1));
  assign last_tog  = (tog_cnt == TW'(2 * DATA_BITS - 1));
  assign last_word = (word_idx == WW'(NUM_WORDS - 1));
  assign leading   = ~tog_cnt[0];
  // With CPHA=1 the final bit is sampled on the very toggle that ends the word.
  assign rx_fin    = cpha ? {rx_sh[DATA_BITS-2:0], MISO} : rx_sh;

  // During XFER the word being loaded is the next one (back-to-back tied bursts).
  assign load_idx  = (state == XFER) ? word_idx + WW'(1) : word_idx;

  always_comb begin
    load_word = tx_lat[DATA_BITS-1:0];
    for (int k = 0; k < NUM_WORDS; k++)
      if (load_idx == WW'(k)) load_word = tx_lat[k*DATA_BITS +: DATA_BITS];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SETUP;
      SETUP:   if (div_end) state_nx = XFER;
      XFER:    if (div_end && last_tog) state_nx = (tied && !last_word) ? XFER : HOLD;
      HOLD:    if (div_end) state_nx = last_word ? DONE : GAP;
      GAP:     if (div_end) state_nx = SETUP;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign SS   = !(state == SETUP || state == XFER || state == HOLD);
  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      tog_cnt  <= '0;
      word_idx <= '0;
      cpha     <= 1'b0;
      tied     <= 1'b0;
      tx_lat   <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_words <= '0;
      SCK      <= 1'b0;
      MOSI     <= 1'b0;
    end else begin
      if (state inside {SETUP, XFER, HOLD, GAP}) div_cnt <= div_end ? '0 : div_cnt + DW'(1);
      else                                       div_cnt <= '0;

      case (state)
        IDLE: begin
          SCK  <= mode[1];
          MOSI <= 1'b0;
          if (start) begin
            cpha     <= mode[0];
            tied     <= tied_SS;
            tx_lat   <= tx_words;
            word_idx <= '0;
            tog_cnt  <= '0;
            MOSI     <= tx_words[DATA_BITS-1];
            tx_sh    <= mode[0] ? tx_words[DATA_BITS-1:0] : {tx_words[DATA_BITS-2:0], 1'b0};
          end
        end
        XFER: if (div_end) begin
          SCK     <= ~SCK;
          tog_cnt <= last_tog ? '0 : tog_cnt + TW'(1);
          if (cpha != leading) rx_sh <= {rx_sh[DATA_BITS-2:0], MISO};
          if (cpha ? leading : (!leading && !last_tog)) begin
            MOSI  <= tx_sh[DATA_BITS-1];
            tx_sh <= {tx_sh[DATA_BITS-2:0], 1'b0};
          end
          if (last_tog) begin
            for (int k = 0; k < NUM_WORDS; k++)
              if (word_idx == WW'(k)) rx_words[k*DATA_BITS +: DATA_BITS] <= rx_fin;
            if (tied && !last_word) begin
              word_idx <= word_idx + WW'(1);
              MOSI     <= load_word[DATA_BITS-1];
              tx_sh    <= cpha ? load_word : {load_word[DATA_BITS-2:0], 1'b0};
            end
          end
        end
        HOLD: if (div_end) begin
          if (!last_word) word_idx <= word_idx + WW'(1);
          else            MOSI     <= 1'b0;
        end
        GAP: if (div_end) begin
          MOSI  <= load_word[DATA_BITS-1];
          tx_sh <= cpha ? load_word : {load_word[DATA_BITS-2:0], 1'b0};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_multiword_master.sv
// tb/tb_spi_multiword_master.sv - bench for spi_multiword_master: timeline model plus directed bursts.
module tb_spi_multiword_master;
  localparam int C = 4, D = 8, W = 4;
  localparam int X = 2 * D * C, P = 2 * C + X, S = P + C;

  logic clk = 1'b0;
  logic reset;
  logic start_a, tied_a, busy_a, done_a, sck_a, ss_a, mosi_a, miso_a;
  logic [1:0] mode_a;
  logic [31:0] tx_a, rx_a;
  logic start_b, busy_b, done_b, sck_b, ss_b, mosi_b;
  logic [15:0] tx_b, rx_b;

  logic use_slave, slave_miso, sck_prev;
  logic [7:0] slave_word;
  int slave_cnt;
  logic [31:0] exp_burst_rx;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign miso_a = use_slave ? slave_miso : mosi_a;

  spi_multiword_master dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode_a), .tied_SS(tied_a),
    .tx_words(tx_a), .rx_words(rx_a), .busy(busy_a), .done(done_a),
    .SCK(sck_a), .SS(ss_a), .MOSI(mosi_a), .MISO(miso_a));

  spi_multiword_master #(.DATA_BITS(16), .NUM_WORDS(1), .CLK_DIV(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(2'b00), .tied_SS(1'b1),
    .tx_words(tx_b), .rx_words(rx_b), .busy(busy_b), .done(done_b),
    .SCK(sck_b), .SS(ss_b), .MOSI(mosi_b), .MISO(mosi_b));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Mode-3 slave: presents the next bit of slave_word half a clk after each falling SCK.
  always @(negedge clk) begin
    if (!busy_a) slave_cnt = 0;
    else if (sck_prev && !sck_a) begin
      slave_miso = slave_word[7 - (slave_cnt % 8)];
      slave_cnt++;
    end
    sck_prev = sck_a;
  end

  // Timeline model: m_n is clk cycles elapsed since start acceptance.
  bit          m_act, m_tied, m_sck_valid;
  int          m_n;
  logic [1:0]  m_mode;
  logic [31:0] m_tx, m_rx_exp, m_rx_prev;
  logic        m_sck_idle;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_act <= 0; m_n <= 0; m_rx_prev <= '0; m_sck_valid <= 0;
    end else if (!m_act) begin
      m_sck_idle <= mode_a[1];
      m_sck_valid <= 1;
      if (start_a) begin
        m_act <= 1; m_n <= 0; m_mode <= mode_a; m_tied <= tied_a;
        m_tx <= tx_a; m_rx_exp <= exp_burst_rx;
      end
    end else begin
      m_sck_valid <= 0;
      if (m_n == (m_tied ? 2*C + W*X : W*P + (W-1)*C)) begin
        m_act <= 0; m_rx_prev <= m_rx_exp;
      end else m_n <= m_n + 1;
    end
  end

  always @(negedge clk) begin
    int L, k, r, h, bi, ph;
    logic e_sck, cpl;
    logic [31:0] erx;
    if (!reset) begin
      chk("rst_ss", ss_a, 1); chk("rst_sck", sck_a, 0); chk("rst_mosi", mosi_a, 0);
      chk("rst_busy", busy_a, 0); chk("rst_done", done_a, 0); chk("rst_rx", rx_a, 0);
    end else if (!m_act) begin
      chk("idle_ss", ss_a, 1); chk("idle_busy", busy_a, 0); chk("idle_done", done_a, 0);
      chk("idle_mosi", mosi_a, 0); chk("idle_rx", rx_a, m_rx_prev);
      if (m_sck_valid) chk("idle_sck", sck_a, m_sck_idle);
    end else begin
      L = m_tied ? 2*C + W*X : W*P + (W-1)*C;
      k = 0; h = 0; ph = 0;  // ph: 0 setup, 1 xfer, 2 hold, 3 gap, 4 done
      if (m_n == L) ph = 4;
      else if (m_tied) begin
        if (m_n < C) ph = 0;
        else if (m_n < C + W*X) begin ph = 1; k = (m_n - C) / X; h = ((m_n - C) % X) / C; end
        else begin ph = 2; k = W - 1; end
      end else begin
        k = m_n / S; r = m_n % S;
        if (r < C) ph = 0;
        else if (r < C + X) begin ph = 1; h = (r - C) / C; end
        else if (r < P) ph = 2;
        else ph = 3;
      end
      e_sck = (ph == 1 && (h % 2) == 1) ? ~m_mode[1] : m_mode[1];
      chk("busy", busy_a, ph != 4); chk("done", done_a, ph == 4);
      chk("ss", ss_a, ph >= 3); chk("sck", sck_a, e_sck);
      if (ph <= 1) begin
        if (ph == 0 || h == 0) bi = D - 1;
        else if (!m_mode[0])   bi = D - 1 - h / 2;
        else                   bi = D - 1 - (h - 1) / 2;
        chk("mosi", mosi_a, m_tx[k*D + bi]);
      end
      for (int j = 0; j < W; j++) begin
        cpl = m_tied ? (m_n >= C + (j+1)*X) : (m_n >= j*S + C + X);
        erx[j*D +: D] = cpl ? m_rx_exp[j*D +: D] : m_rx_prev[j*D +: D];
      end
      chk("rx_progress", rx_a, erx);
    end
  end

  task automatic run_burst(input logic [1:0] md, input logic td, input logic [31:0] tx,
                           input logic [31:0] erx, input int elen, input int egaps,
                           input logic slave, input int pulse_at);
    int cyc, gaps;
    @(negedge clk);
    mode_a = md; tied_a = td; tx_a = tx; exp_burst_rx = erx; use_slave = slave; start_a = 1;
    @(negedge clk);
    start_a = 0; cyc = 0; gaps = 0;
    while (!done_a && cyc < 2000) begin
      if (ss_a && busy_a) gaps++;
      @(negedge clk);
      cyc++;
      if (cyc == 20) begin tx_a = ~tx; mode_a = ~md; tied_a = ~td; end
      if (cyc == pulse_at) start_a = 1;
      if (cyc == pulse_at + 1) start_a = 0;
    end
    chk("burst_len", cyc, elen);
    chk("burst_rx", rx_a, erx);
    chk("ss_gap_cycles", gaps, egaps);
  endtask

  task automatic run_held();
    int cyc;
    @(negedge clk);
    mode_a = 2'b10; tied_a = 1; tx_a = 32'h5A3CC381; exp_burst_rx = 32'h5A3CC381;
    use_slave = 0; start_a = 1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      cyc = 0;
      while (!done_a && cyc < 2000) begin @(negedge clk); cyc++; end
      chk("held_len", cyc, 264);
      chk("held_rx", rx_a, 32'h5A3CC381);
      if (b == 0) begin
        @(negedge clk);
        chk("held_idle_gap", busy_a, 0);
      end else start_a = 0;
    end
  endtask

  initial begin
    int cyc;
    reset = 0; start_a = 0; mode_a = 2'b00; tied_a = 0; tx_a = '0; exp_burst_rx = '0;
    start_b = 0; tx_b = '0; use_slave = 0; slave_miso = 0; sck_prev = 0; slave_word = 8'hA5;
    #1;
    chk("init_ss", ss_a, 1); chk("init_busy", busy_a, 0); chk("init_rx", rx_a, 0);
    chk("init_b_ss", ss_b, 1); chk("init_b_sck", sck_b, 0);
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (2) @(negedge clk);

    run_burst(2'b00, 1'b1, 32'hFEFCFBFA, 32'hFEFCFBFA, 264, 0, 1'b0, 50);
    run_burst(2'b00, 1'b0, 32'hFEFCFBFA, 32'hFEFCFBFA, 300, 12, 1'b0, 0);
    run_burst(2'b11, 1'b1, 32'h0F1E2D3C, 32'hA5A5A5A5, 264, 0, 1'b1, 0);
    mode_a = 2'b11;
    repeat (3) @(negedge clk);
    chk("mode3_sck_idle_high", sck_a, 1);
    run_burst(2'b01, 1'b0, 32'h81422418, 32'h81422418, 300, 12, 1'b0, 50);
    run_held();

    // Abort during word 2 (cycles 132..195 of a tied burst).
    @(negedge clk);
    mode_a = 2'b00; tied_a = 1; tx_a = 32'hC0FFEE11; exp_burst_rx = 32'hC0FFEE11; start_a = 1;
    @(negedge clk);
    start_a = 0;
    repeat (142) @(negedge clk);
    #2 reset = 0;
    #1;
    chk("abort_ss", ss_a, 1); chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0); chk("abort_rx", rx_a, 0);
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (30) @(negedge clk);
    chk("abort_no_restart", busy_a, 0);
    run_burst(2'b00, 1'b1, 32'h13579BDF, 32'h13579BDF, 264, 0, 1'b0, 0);

    @(negedge clk);
    tx_b = 16'h1234; start_b = 1;
    @(negedge clk);
    start_b = 0; cyc = 0;
    while (!done_b && cyc < 500) begin @(negedge clk); cyc++; end
    chk("b_len", cyc, 68);
    chk("b_rx", rx_b, 16'h1234);
    chk("b_busy_at_done", busy_b, 0);
    @(negedge clk);
    chk("b_idle_ss", ss_b, 1);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, failed so far %0d", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
